// File: rtl/uart_tx_reporter_pkg.sv
// Shared types and constants for the UART TX status reporter.
// Holds the FSM encoding, ASCII codes and message geometry.
package uart_tx_reporter_pkg;

  localparam int CNT_W   = 14;
  localparam int MAX_CNT = 9999;
  localparam int MSG_LEN = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_C  = 8'h43;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic logic [7:0] digitChar(input logic [3:0] nibble);
    return ASCII_0 + {4'd0, nibble};
  endfunction

endpackage

// File: rtl/uart_tx_reporter_if.sv
// Request/FIFO-write bundle between the reporter and its surroundings.
// The slave modport is the reporter's view.
interface uart_tx_reporter_if;
  logic       send;
  logic       tx_full;
  logic [7:0] tx_data;
  logic       wr_en;
  logic       busy;

  modport master (output send, tx_full, input tx_data, wr_en, busy);
  modport slave  (input send, tx_full, output tx_data, wr_en, busy);
endinterface

// File: rtl/uart_tx_reporter_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// A start pulse loads the value; o_done flags the cycle of the final step.
module bin2bcd_seq #(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_bin,
  output logic             o_done,
  output logic [15:0]      o_bcd
);

  localparam int STEP_W = $clog2(CNT_W + 1);

  logic [CNT_W-1:0]  r_bin;
  logic [15:0]       r_bcd;
  logic [STEP_W-1:0] r_step;
  logic              r_active;
  logic [15:0]       w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Done is raised while the last step is in flight so the caller can
  // move on at the same edge that lands the final BCD value.
  assign o_done = r_active && (r_step == STEP_W'(CNT_W - 1));
  assign o_bcd  = r_bcd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin    <= '0;
      r_bcd    <= '0;
      r_step   <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_bin    <= i_bin;
      r_bcd    <= '0;
      r_step   <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_bcd  <= {w_adj[14:0], r_bin[CNT_W-1]};
      r_bin  <= {r_bin[CNT_W-2:0], 1'b0};
      r_step <= r_step + 1'b1;
      if (o_done) r_active <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_reporter.sv
// Snapshots count and mode, converts to decimal and writes a 7-byte
// status line ("M dddd CR LF") into the UART TX FIFO.
module uart_tx_reporter
  import uart_tx_reporter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_run_on,
  input  logic             i_clr_on,
  uart_tx_reporter_if.slave bus
);

  state_t           r_state;
  state_t           w_nextState;
  logic [7:0]       r_mode;
  logic [2:0]       r_idx;
  logic             r_pending;
  logic [CNT_W-1:0] w_satCount;
  logic [7:0]       w_modeChar;
  logic             w_start;
  logic             w_lastWrite;
  logic             w_restart;
  logic             w_done;
  logic [15:0]      w_bcd;
  logic             w_wrEn;
  logic [7:0]       w_txData;
  logic             w_busy;

  assign w_satCount = (i_count > CNT_W'(MAX_CNT)) ? CNT_W'(MAX_CNT) : i_count;
  assign w_modeChar = i_clr_on ? ASCII_C : (i_run_on ? ASCII_R : ASCII_S);

  // A request arriving on the final write edge counts as pending too.
  assign w_lastWrite = (r_state == SEND) && w_wrEn && (r_idx == 3'(MSG_LEN - 1));
  assign w_restart   = w_lastWrite && (r_pending || bus.send);
  assign w_start     = ((r_state == IDLE) && bus.send) || w_restart;

  bin2bcd_seq #(.CNT_W(CNT_W)) u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_start),
    .i_bin   (w_satCount),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.send) w_nextState = CONV;
      CONV:    if (w_done) w_nextState = SEND;
      SEND:    if (w_lastWrite) w_nextState = w_restart ? CONV : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_wrEn   = 1'b0;
    w_txData = 8'h00;
    w_busy   = (r_state != IDLE);
    if (r_state == SEND) begin
      w_wrEn = ~bus.tx_full;
      case (r_idx)
        3'd0:    w_txData = r_mode;
        3'd1:    w_txData = digitChar(w_bcd[15:12]);
        3'd2:    w_txData = digitChar(w_bcd[11:8]);
        3'd3:    w_txData = digitChar(w_bcd[7:4]);
        3'd4:    w_txData = digitChar(w_bcd[3:0]);
        3'd5:    w_txData = ASCII_CR;
        3'd6:    w_txData = ASCII_LF;
        default: w_txData = 8'h00;
      endcase
    end
  end

  assign bus.wr_en   = w_wrEn;
  assign bus.tx_data = w_txData;
  assign bus.busy    = w_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode    <= 8'h00;
      r_idx     <= 3'd0;
      r_pending <= 1'b0;
    end else begin
      if (w_start) r_mode <= w_modeChar;
      if (w_start || w_lastWrite) r_idx <= 3'd0;
      else if (w_wrEn)            r_idx <= r_idx + 3'd1;
      if (w_restart)                          r_pending <= 1'b0;
      else if (bus.send && r_state != IDLE)   r_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_reporter.sv
// Scoreboard bench: stimulus pushes hand-computed bytes with their write
// edge; a negedge monitor pops and compares every FIFO write.
module tb_uart_tx_reporter;

  typedef struct {
    logic [7:0] data;
    int         wrEdge;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] count;
  logic        runOn;
  logic        clrOn;
  int          cycleCount = 0;
  int          testsRun = 0;
  int          testsFailed = 0;
  int          e0;
  exp_t        expQ[$];

  uart_tx_reporter_if bus ();

  uart_tx_reporter dut (
    .clk      (clk),
    .reset    (reset),
    .i_count  (count),
    .i_run_on (runOn),
    .i_clr_on (clrOn),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Every write must match the oldest expected byte, both value and edge.
  always @(negedge clk) begin
    if (!reset && bus.wr_en) begin
      testsRun++;
      if (expQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL unexpectedWrite: got 0x%02h, required no write", bus.tx_data);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        if (bus.tx_data !== e.data) begin
          testsFailed++;
          $display("[TB] FAIL byteData: got 0x%02h, required 0x%02h", bus.tx_data, e.data);
        end
        testsRun++;
        if (cycleCount + 1 != e.wrEdge) begin
          testsFailed++;
          $display("[TB] FAIL byteEdge: got edge %0d, required edge %0d", cycleCount + 1, e.wrEdge);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitEdge(input int n);
    while (cycleCount < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [13:0] c, input logic run, input logic clr, output int edge0);
    count    = c;
    runOn    = run;
    clrOn    = clr;
    bus.send = 1'b1;
    @(posedge clk);
    #1;
    edge0    = cycleCount;
    bus.send = 1'b0;
  endtask

  task automatic pushMsg(input logic [39:0] head, input int edge0, input int stallIdx, input int stallLen);
    for (int k = 0; k < 7; k++) begin
      exp_t e;
      if (k < 5)       e.data = head[39 - 8*k -: 8];
      else if (k == 5) e.data = 8'h0D;
      else             e.data = 8'h0A;
      e.wrEdge = edge0 + 15 + k + ((k >= stallIdx) ? stallLen : 0);
      expQ.push_back(e);
    end
  endtask

  task automatic checkDrained(input string name);
    int n = 0;
    while ((expQ.size() != 0 || bus.busy) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, {15'd0, (expQ.size() == 0 && !bus.busy)}, 16'd1);
    expQ.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    bus.send    = 1'b0;
    bus.tx_full = 1'b0;
    count       = '0;
    runOn       = 1'b0;
    clrOn       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetWrEn", {15'd0, bus.wr_en}, 16'd0);
    checkOutput("resetData", {8'd0, bus.tx_data}, 16'h00);
    checkOutput("resetBusy", {15'd0, bus.busy}, 16'd0);
    reset = 1'b0;
    waitEdge(cycleCount + 2);

    applyStimulus(14'd1234, 1'b1, 1'b0, e0);
    pushMsg(40'h52_31_32_33_34, e0, 7, 0);
    waitEdge(e0 + 20);
    checkOutput("busyBeforeLast", {15'd0, bus.busy}, 16'd1);
    waitEdge(e0 + 21);
    checkOutput("busyAfterLast", {15'd0, bus.busy}, 16'd0);
    checkDrained("run1234");

    applyStimulus(14'd0, 1'b0, 1'b0, e0);
    pushMsg(40'h53_30_30_30_30, e0, 7, 0);
    checkDrained("stop0000");

    applyStimulus(14'd1234, 1'b1, 1'b1, e0);
    pushMsg(40'h43_31_32_33_34, e0, 7, 0);
    checkDrained("clearWins");

    applyStimulus(14'd12000, 1'b1, 1'b0, e0);
    pushMsg(40'h52_39_39_39_39, e0, 7, 0);
    checkDrained("saturate");

    applyStimulus(14'd9999, 1'b0, 1'b0, e0);
    pushMsg(40'h53_39_39_39_39, e0, 7, 0);
    checkDrained("max9999");

    applyStimulus(14'd7, 1'b1, 1'b0, e0);
    pushMsg(40'h52_30_30_30_37, e0, 7, 0);
    checkDrained("count7");

    // FIFO full for three cycles while the hundreds digit is presented.
    applyStimulus(14'd1234, 1'b1, 1'b0, e0);
    pushMsg(40'h52_31_32_33_34, e0, 2, 3);
    waitEdge(e0 + 16);
    bus.tx_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stallWrEn", {15'd0, bus.wr_en}, 16'd0);
      checkOutput("stallData", {8'd0, bus.tx_data}, 16'h32);
      waitEdge(e0 + 17 + i);
    end
    bus.tx_full = 1'b0;
    checkDrained("stall");

    // Three requests during CONV coalesce into a single follow-up report.
    applyStimulus(14'd100, 1'b1, 1'b0, e0);
    pushMsg(40'h52_30_31_30_30, e0, 7, 0);
    waitEdge(e0 + 2);  count = 14'd555; bus.send = 1'b1;
    waitEdge(e0 + 3);  bus.send = 1'b0;
    waitEdge(e0 + 5);  bus.send = 1'b1;
    waitEdge(e0 + 6);  bus.send = 1'b0;
    waitEdge(e0 + 8);  bus.send = 1'b1;
    waitEdge(e0 + 9);  bus.send = 1'b0;
    waitEdge(e0 + 17); count = 14'd4321;
    pushMsg(40'h52_34_33_32_31, e0 + 21, 7, 0);
    waitEdge(e0 + 22); count = 14'd1111;
    waitEdge(e0 + 60);
    checkOutput("coalesceIdle", {15'd0, bus.busy}, 16'd0);
    checkDrained("coalesce");

    // Request arriving exactly on the final write edge.
    applyStimulus(14'd42, 1'b0, 1'b0, e0);
    pushMsg(40'h53_30_30_34_32, e0, 7, 0);
    waitEdge(e0 + 20); bus.send = 1'b1; count = 14'd88;
    waitEdge(e0 + 21); bus.send = 1'b0;
    pushMsg(40'h53_30_30_38_38, e0 + 21, 7, 0);
    checkDrained("lastEdgeSend");

    // Reset while the ones digit is presented abandons the message.
    applyStimulus(14'd1234, 1'b0, 1'b1, e0);
    pushMsg(40'h43_31_32_33_34, e0, 7, 0);
    waitEdge(e0 + 18);
    reset = 1'b1;
    #1;
    checkOutput("midResetWrEn", {15'd0, bus.wr_en}, 16'd0);
    checkOutput("midResetBusy", {15'd0, bus.busy}, 16'd0);
    checkOutput("midResetData", {8'd0, bus.tx_data}, 16'h00);
    checkOutput("partialCount", 16'(expQ.size()), 16'd3);
    expQ.delete();
    waitEdge(e0 + 20);
    reset = 1'b0;
    waitEdge(cycleCount + 2);
    applyStimulus(14'd9, 1'b1, 1'b0, e0);
    pushMsg(40'h52_30_30_30_39, e0, 7, 0);
    checkDrained("afterReset");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
